// File: rtl/jtag_pkg.sv
// jtag_pkg -- shared definitions for the JTAG TAP controller.
//   tap_state_e     : the 16 TAP states in the IEEE 1149.1 4-bit encoding
//   IDCODE_LENGTH   : width of the IDCODE data register
//   is_bypass()     : true when the low 'len' bits of an instruction are all ones
package jtag_pkg;

   typedef enum logic [3:0] {
      EXIT2_DR         = 4'h0,
      EXIT1_DR         = 4'h1,
      SHIFT_DR         = 4'h2,
      PAUSE_DR         = 4'h3,
      SELECT_IR_SCAN   = 4'h4,
      UPDATE_DR        = 4'h5,
      CAPTURE_DR       = 4'h6,
      SELECT_DR_SCAN   = 4'h7,
      EXIT2_IR         = 4'h8,
      EXIT1_IR         = 4'h9,
      SHIFT_IR         = 4'hA,
      PAUSE_IR         = 4'hB,
      RUN_TEST_IDLE    = 4'hC,
      UPDATE_IR        = 4'hD,
      CAPTURE_IR       = 4'hE,
      TEST_LOGIC_RESET = 4'hF
   } tap_state_e;

   localparam int IDCODE_LENGTH = 32;

   // Instructions are passed zero-extended to 32 bits so one helper serves
   // any instruction width up to 32.
   function automatic logic is_bypass(input logic [31:0] instr, input int unsigned len);
      logic [31:0] mask;
      mask = 32'hFFFF_FFFF >> (32 - len);
      return (instr & mask) == mask;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm -- IEEE 1149.1 TAP state machine.
//   tck, reset, tms     : clock, synchronous active-high reset, mode select
//   tap_state           : current state encoding
//   tap_state_next      : state that will be entered at the next tck edge
//   capture_dr .. test_logic_reset : one-hot decodes of the current state
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       tck,
   input  logic       reset,
   input  logic       tms,
   output logic [3:0] tap_state,
   output logic [3:0] tap_state_next,
   output logic       capture_dr,
   output logic       shift_dr,
   output logic       update_dr,
   output logic       capture_ir,
   output logic       shift_ir,
   output logic       update_ir,
   output logic       test_logic_reset
);

   tap_state_e state_reg;
   tap_state_e state_next;

   always_ff @(posedge tck) begin
      if (reset) begin
         state_reg <= TEST_LOGIC_RESET;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         TEST_LOGIC_RESET: state_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    state_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   state_next = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
         CAPTURE_DR:       state_next = tms ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         state_next = tms ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         state_next = tms ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         state_next = tms ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         state_next = tms ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        state_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   state_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       state_next = tms ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         state_next = tms ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         state_next = tms ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         state_next = tms ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         state_next = tms ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        state_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         default:          state_next = TEST_LOGIC_RESET;
      endcase
   end

   assign tap_state        = state_reg;
   assign tap_state_next   = state_next;
   assign capture_dr       = (state_reg == CAPTURE_DR);
   assign shift_dr         = (state_reg == SHIFT_DR);
   assign update_dr        = (state_reg == UPDATE_DR);
   assign capture_ir       = (state_reg == CAPTURE_IR);
   assign shift_ir         = (state_reg == SHIFT_IR);
   assign update_ir        = (state_reg == UPDATE_IR);
   assign test_logic_reset = (state_reg == TEST_LOGIC_RESET);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl -- JTAG TAP controller with IR, BYPASS and IDCODE registers.
//   tck, reset        : clock and synchronous active-high reset
//   tms, tdi          : TAP mode select and serial data in (LSB first)
//   tdo, tdo_oe       : serial data out and its enable (Shift-DR/Shift-IR)
//   user_tdo          : serial return from an external user data register
//   ir                : current instruction
//   user_select       : instruction is neither BYPASS nor IDCODE
//   tap_state         : current TAP state encoding
//   capture_dr .. test_logic_reset : state decodes for external registers
module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   parameter int                   IR_LENGTH    = 4,
   parameter logic [31:0]          IDCODE_VALUE = 32'h020F30DD,
   parameter logic [IR_LENGTH-1:0] IDCODE_INSTR = 4'b0110,
   parameter logic [IR_LENGTH-1:0] IR_CAPTURE   = 4'b0101
) (
   input  logic                 tck,
   input  logic                 reset,
   input  logic                 tms,
   input  logic                 tdi,
   output logic                 tdo,
   output logic                 tdo_oe,
   input  logic                 user_tdo,
   output logic [IR_LENGTH-1:0] ir,
   output logic                 user_select,
   output logic [3:0]           tap_state,
   output logic                 capture_dr,
   output logic                 shift_dr,
   output logic                 update_dr,
   output logic                 capture_ir,
   output logic                 shift_ir,
   output logic                 update_ir,
   output logic                 test_logic_reset
);

   logic [3:0]               tap_state_next;
   logic [IR_LENGTH-1:0]     ir_reg;
   logic [IR_LENGTH-1:0]     ir_shift_reg;
   logic                     bypass_reg;
   logic [IDCODE_LENGTH-1:0] idcode_reg;
   logic [31:0]              ir_ext;
   logic                     bypass_sel;
   logic                     idcode_sel;
   logic                     ir_reset;

   jtag_tap_fsm u_fsm (
      .tck              (tck),
      .reset            (reset),
      .tms              (tms),
      .tap_state        (tap_state),
      .tap_state_next   (tap_state_next),
      .capture_dr       (capture_dr),
      .shift_dr         (shift_dr),
      .update_dr        (update_dr),
      .capture_ir       (capture_ir),
      .shift_ir         (shift_ir),
      .update_ir        (update_ir),
      .test_logic_reset (test_logic_reset)
   );

   assign ir_ext      = 32'(ir_reg);
   assign bypass_sel  = is_bypass(ir_ext, IR_LENGTH);
   assign idcode_sel  = (ir_reg == IDCODE_INSTR);
   assign user_select = !bypass_sel && !idcode_sel;

   // The instruction is forced to IDCODE on the edge that enters
   // Test-Logic-Reset as well as on every edge spent there, so ir already
   // reads IDCODE in the first cycle of Test-Logic-Reset.
   assign ir_reset = test_logic_reset || (tap_state_next == TEST_LOGIC_RESET);

   always_ff @(posedge tck) begin
      if (reset) begin
         ir_reg <= IDCODE_INSTR;
      end else if (ir_reset) begin
         ir_reg <= IDCODE_INSTR;
      end else if (update_ir) begin
         ir_reg <= ir_shift_reg;
      end
   end

   always_ff @(posedge tck) begin
      if (reset) begin
         ir_shift_reg <= IR_CAPTURE;
      end else if (capture_ir) begin
         ir_shift_reg <= IR_CAPTURE;
      end else if (shift_ir) begin
         ir_shift_reg <= {tdi, ir_shift_reg[IR_LENGTH-1:1]};
      end
   end

   // Data registers only move in Capture-DR/Shift-DR of their own
   // instruction; pause and exit states leave them untouched.
   always_ff @(posedge tck) begin
      if (reset) begin
         bypass_reg <= 1'b0;
      end else if (bypass_sel && capture_dr) begin
         bypass_reg <= 1'b0;
      end else if (bypass_sel && shift_dr) begin
         bypass_reg <= tdi;
      end
   end

   always_ff @(posedge tck) begin
      if (reset) begin
         idcode_reg <= IDCODE_VALUE;
      end else if (idcode_sel && capture_dr) begin
         idcode_reg <= IDCODE_VALUE;
      end else if (idcode_sel && shift_dr) begin
         idcode_reg <= {tdi, idcode_reg[IDCODE_LENGTH-1:1]};
      end
   end

   // tdo is combinational so the captured LSB is visible in the first cycle
   // of a Shift state; N shift edges therefore return N captured bits.
   always_comb begin
      tdo = 1'b0;
      if (shift_ir) begin
         tdo = ir_shift_reg[0];
      end else if (shift_dr) begin
         if (bypass_sel) begin
            tdo = bypass_reg;
         end else if (idcode_sel) begin
            tdo = idcode_reg[0];
         end else begin
            tdo = user_tdo;
         end
      end
   end

   assign tdo_oe = shift_dr || shift_ir;
   assign ir     = ir_reg;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl -- directed self-checking bench for jtag_tap_ctrl.
// Expected tdo bits are queued when a scan is set up and popped as the DUT
// shifts them out.
module tb_jtag_tap_ctrl;

   logic       tck = 1'b0;
   logic       reset;
   logic       tms;
   logic       tdi;
   logic       user_tdo;
   logic       tdo;
   logic       tdo_oe;
   logic [3:0] ir;
   logic       user_select;
   logic [3:0] tap_state;
   logic       capture_dr, shift_dr, update_dr;
   logic       capture_ir, shift_ir, update_ir;
   logic       test_logic_reset;

   int         n_assert = 0;
   int         n_fail   = 0;
   logic       exp_q[$];
   logic       exp_bit;
   logic [31:0] idcode_exp = 32'h020F30DD;
   logic [7:0]  byp_data   = 8'hA5;
   logic [3:0]  ir_all1    = 4'b1111;
   logic [3:0]  ir_user    = 4'b0010;
   logic [3:0]  ir_cap     = 4'b0101;

   jtag_tap_ctrl dut (
      .tck              (tck),
      .reset            (reset),
      .tms              (tms),
      .tdi              (tdi),
      .tdo              (tdo),
      .tdo_oe           (tdo_oe),
      .user_tdo         (user_tdo),
      .ir               (ir),
      .user_select      (user_select),
      .tap_state        (tap_state),
      .capture_dr       (capture_dr),
      .shift_dr         (shift_dr),
      .update_dr        (update_dr),
      .capture_ir       (capture_ir),
      .shift_ir         (shift_ir),
      .update_ir        (update_ir),
      .test_logic_reset (test_logic_reset)
   );

   always #5 tck = ~tck;

   function automatic logic [31:0] decodes();
      return 32'({capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir, test_logic_reset});
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_tdo(input string tag);
      if (exp_q.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL %s observed=%b expected=<scoreboard empty>", tag, tdo);
      end else begin
         exp_bit = exp_q.pop_front();
         chk(tag, 32'(tdo), 32'(exp_bit));
      end
   endtask

   // Drive inputs just after a rising edge, take one edge, settle.
   task automatic tick(input logic m, input logic d);
      tms = m;
      tdi = d;
      @(posedge tck);
      #1;
   endtask

   task automatic push_ir_capture();
      for (int i = 0; i < 4; i++) exp_q.push_back(ir_cap[i]);
   endtask

   initial begin
      reset    = 1'b1;
      tms      = 1'b1;
      tdi      = 1'b0;
      user_tdo = 1'b0;
      #1;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      chk("rst_state", 32'(tap_state), 32'hF);
      chk("rst_ir", 32'(ir), 32'h6);
      chk("rst_tdo", 32'(tdo), 32'h0);
      chk("rst_tdo_oe", 32'(tdo_oe), 32'h0);
      chk("rst_decodes", decodes(), 32'h01);
      chk("rst_user_select", 32'(user_select), 32'h0);
      reset = 1'b0;

      // IDCODE DR scan, 32 edges, tdi=0
      tick(1'b0, 1'b0);
      chk("rti_state", 32'(tap_state), 32'hC);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk("cap_dr_decodes", decodes(), 32'h40);
      tick(1'b0, 1'b0);
      chk("shift_dr_oe", 32'(tdo_oe), 32'h1);
      for (int i = 0; i < 32; i++) exp_q.push_back(idcode_exp[i]);
      for (int i = 0; i < 32; i++) begin
         chk_tdo("idcode_tdo");
         tick(logic'(i == 31), 1'b0);
      end
      chk("exit1_dr_state", 32'(tap_state), 32'h1);
      chk("exit1_dr_tdo", 32'(tdo), 32'h0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      $display("scan IDCODE DR 32 bits done, state=%h", tap_state);

      // IR scan shifting 1111
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      chk("shift_ir_decodes", decodes(), 32'h04);
      push_ir_capture();
      for (int i = 0; i < 4; i++) begin
         chk_tdo("ir_capture_tdo");
         tick(logic'(i == 3), ir_all1[i]);
      end
      tick(1'b1, 1'b0);
      chk("ir_hold_pre_update", 32'(ir), 32'h6);
      tick(1'b0, 1'b0);
      chk("ir_bypass", 32'(ir), 32'hF);
      chk("bypass_user_select", 32'(user_select), 32'h0);
      $display("scan IR 1111 done, ir=%h", ir);

      // BYPASS DR scan of 8 edges, with a Pause-DR detour after edge 4
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 7; i++) exp_q.push_back(byp_data[i]);
      for (int i = 0; i < 8; i++) begin
         chk_tdo("bypass_tdo");
         if (i == 3) begin
            tick(1'b1, byp_data[3]);
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b0);
            chk("pause_dr_state", 32'(tap_state), 32'h3);
            chk("pause_dr_tdo_oe", 32'(tdo_oe), 32'h0);
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
         end else begin
            tick(logic'(i == 7), byp_data[i]);
         end
      end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      $display("scan BYPASS DR 8 bits done, state=%h", tap_state);

      // IR scan loading a user instruction 0010
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      push_ir_capture();
      for (int i = 0; i < 4; i++) begin
         chk_tdo("ir_capture_tdo2");
         tick(logic'(i == 3), ir_user[i]);
      end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk("ir_user", 32'(ir), 32'h2);
      chk("user_select_hi", 32'(user_select), 32'h1);
      $display("scan IR 0010 done, ir=%h", ir);

      // User DR scan: tdo follows user_tdo
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         user_tdo = 1'($urandom_range(0, 1));
         #1;
         exp_q.push_back(user_tdo);
         chk_tdo("user_tdo");
         tick(logic'(i == 5), 1'b0);
      end
      chk("update_dr_before", 32'(update_dr), 32'h0);
      tick(1'b1, 1'b0);
      chk("update_dr_pulse", 32'(update_dr), 32'h1);
      tick(1'b0, 1'b0);
      chk("update_dr_after", 32'(update_dr), 32'h0);
      user_tdo = 1'b1;
      #1;
      chk("idle_tdo_zero", 32'(tdo), 32'h0);
      $display("scan user DR 6 bits done, state=%h", tap_state);

      // Five tms=1 edges from Pause-IR
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk("pause_ir_state", 32'(tap_state), 32'hB);
      repeat (5) tick(1'b1, 1'b0);
      chk("tms5_state", 32'(tap_state), 32'hF);
      chk("tms5_ir", 32'(ir), 32'h6);
      $display("tms reset from Pause-IR done, state=%h ir=%h", tap_state, ir);

      // reset asserted at the fourth Shift-DR edge
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      repeat (3) tick(1'b0, 1'b1);
      chk("mid_shift_oe", 32'(tdo_oe), 32'h1);
      reset = 1'b1;
      tick(1'b0, 1'b1);
      chk("midrst_state", 32'(tap_state), 32'hF);
      chk("midrst_tdo", 32'(tdo), 32'h0);
      chk("midrst_tdo_oe", 32'(tdo_oe), 32'h0);
      chk("midrst_decodes", decodes(), 32'h01);
      reset = 1'b0;
      tick(1'b0, 1'b0);
      chk("post_rst_rti", 32'(tap_state), 32'hC);
      $display("reset during Shift-DR done, state=%h", tap_state);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
